// File: rtl/control_satd_differences.sv
// control_satd_differences
//   Sequences one pass over sixteen 64-bit slices of a pair of 1024-bit
//   operands and produces eight registered signed byte differences per slice
//   (ORG sample minus CUR sample) for a downstream SATD transform.
//
//   The control FSM runs IDLE -> RUN (16 cycles) -> DONE. DONE is terminal;
//   only rst leaves it. All outputs are Moore outputs decoded from state and
//   registers.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (FSM, counter and differences)
//   ORG          eight unsigned original samples, sample k = ORG[8k+7:8k]
//   CUR          eight unsigned current samples,  sample k = CUR[8k+7:8k]
//   ENABLE_DIFF  high in RUN; the parent presents slice COUNTER on ORG/CUR
//   RESET_DIFF   high in IDLE; clears the difference registers
//   COUNTER      index of the current 64-bit slice, 0..15
//   diff_0..7    registered signed differences, range -255..+255
module control_satd_differences #(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*DATA_W-1:0]      ORG,
  input  logic [8*DATA_W-1:0]      CUR,
  output logic                     ENABLE_DIFF,
  output logic                     RESET_DIFF,
  output logic [3:0]               COUNTER,
  output logic signed [DATA_W:0]   diff_0,
  output logic signed [DATA_W:0]   diff_1,
  output logic signed [DATA_W:0]   diff_2,
  output logic signed [DATA_W:0]   diff_3,
  output logic signed [DATA_W:0]   diff_4,
  output logic signed [DATA_W:0]   diff_5,
  output logic signed [DATA_W:0]   diff_6,
  output logic signed [DATA_W:0]   diff_7
);

  localparam int LANES = 8;
  localparam logic [3:0] LAST_SLICE = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [3:0] cnt_q;

  logic signed [DATA_W:0] diff_p1 [LANES];

  // Zero-extending both operands by one bit makes the full -255..+255 range
  // representable, so the subtraction can never overflow.
  function automatic logic signed [DATA_W:0] lane_diff(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (cnt_q == LAST_SLICE) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ENABLE_DIFF = 1'b0;
    RESET_DIFF  = 1'b0;
    case (state_q)
      IDLE:    RESET_DIFF  = 1'b1;
      RUN:     ENABLE_DIFF = 1'b1;
      default: ;
    endcase
  end

  // Slice counter: parked at 0 in IDLE, counts through RUN, and stops on the
  // last slice instead of wrapping so DONE keeps reporting 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE:    cnt_q <= 4'd0;
        RUN:     if (cnt_q != LAST_SLICE) cnt_q <= cnt_q + 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign COUNTER = cnt_q;

  // Stage p0 -> p1: one-cycle registered difference per lane; clear wins
  // over load.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (rst || RESET_DIFF) begin
        diff_p1[k] <= '0;
      end else if (ENABLE_DIFF) begin
        diff_p1[k] <= lane_diff(ORG[k*DATA_W +: DATA_W], CUR[k*DATA_W +: DATA_W]);
      end
    end
  end

  assign diff_0 = diff_p1[0];
  assign diff_1 = diff_p1[1];
  assign diff_2 = diff_p1[2];
  assign diff_3 = diff_p1[3];
  assign diff_4 = diff_p1[4];
  assign diff_5 = diff_p1[5];
  assign diff_6 = diff_p1[6];
  assign diff_7 = diff_p1[7];

endmodule

// File: tb/tb_control_satd_differences.sv
// Bench for control_satd_differences: directed vectors, a cycle-level
// behavioural model of the slice sequence and lane differences, and literal
// expectations at key points.
module tb_control_satd_differences;

  logic        clk;
  logic        rst;
  logic [63:0] ORG;
  logic [63:0] CUR;
  logic        ENABLE_DIFF;
  logic        RESET_DIFF;
  logic [3:0]  COUNTER;
  logic signed [8:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic signed [8:0] dq [8];

  int checks = 0;
  int errors = 0;

  // Model: t = cycles since the last reset edge (0 = IDLE, 1..16 = RUN, 17 = DONE)
  int t = 0;
  bit armed = 1'b0;
  int md [8];

  logic [63:0] vo [16];
  logic [63:0] vc [16];

  control_satd_differences dut (
    .clk(clk), .rst(rst), .ORG(ORG), .CUR(CUR),
    .ENABLE_DIFF(ENABLE_DIFF), .RESET_DIFF(RESET_DIFF), .COUNTER(COUNTER),
    .diff_0(d0), .diff_1(d1), .diff_2(d2), .diff_3(d3),
    .diff_4(d4), .diff_5(d5), .diff_6(d6), .diff_7(d7)
  );

  assign dq[0] = d0;
  assign dq[1] = d1;
  assign dq[2] = d2;
  assign dq[3] = d3;
  assign dq[4] = d4;
  assign dq[5] = d5;
  assign dq[6] = d6;
  assign dq[7] = d7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      armed = 1'b1;
      for (int k = 0; k < 8; k++) md[k] = 0;
    end else if (armed) begin
      if (t == 0) begin
        for (int k = 0; k < 8; k++) md[k] = 0;
      end else if (t <= 16) begin
        for (int k = 0; k < 8; k++) md[k] = int'(ORG[8*k +: 8]) - int'(CUR[8*k +: 8]);
      end
      if (t < 17) t = t + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    int exp_cnt;
    exp_cnt = (t == 0) ? 0 : ((t <= 16) ? t - 1 : 15);
    chk("no_x", int'($isunknown({ENABLE_DIFF, RESET_DIFF, COUNTER, d0, d1, d2, d3, d4, d5, d6, d7})), 0);
    chk("ENABLE_DIFF", int'(ENABLE_DIFF), (t >= 1 && t <= 16) ? 1 : 0);
    chk("RESET_DIFF", int'(RESET_DIFF), (t == 0) ? 1 : 0);
    chk("COUNTER", int'(COUNTER), exp_cnt);
    for (int k = 0; k < 8; k++) chk($sformatf("diff_%0d", k), int'(dq[k]), md[k]);
  endtask

  // One cycle: compare at the falling edge, then change inputs just after it.
  task automatic drive(input logic [63:0] o, input logic [63:0] c, input logic r);
    @(negedge clk);
    if (armed) compare_model();
    #1;
    ORG = o;
    CUR = c;
    rst = r;
  endtask

  task automatic chk_diffs(input string tag, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int e5, input int e6, input int e7);
    int e [8];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    for (int k = 0; k < 8; k++) chk($sformatf("%s_diff_%0d", tag, k), int'(dq[k]), e[k]);
  endtask

  localparam logic [63:0] EXT_O = 64'h00FF_00FF_5A5A_00FF;
  localparam logic [63:0] EXT_C = 64'hFF00_FF00_5A5A_FF00;

  initial begin
    rst = 1'b1;
    ORG = '0;
    CUR = '0;

    vo[0] = 64'h0807060504030201;
    vc[0] = 64'h0102030405060708;
    vo[1] = EXT_O;
    vc[1] = EXT_C;
    for (int i = 2; i < 15; i++) begin
      vo[i] = {$urandom, $urandom};
      vc[i] = {$urandom, $urandom};
    end
    vo[15] = EXT_O;
    vc[15] = EXT_C;

    // Held reset: stays in IDLE with counter 0
    repeat (4) drive('0, '0, 1'b1);
    chk("held_rst_enable", int'(ENABLE_DIFF), 0);
    chk("held_rst_reset_diff", int'(RESET_DIFF), 1);
    chk("held_rst_counter", int'(COUNTER), 0);

    // Release: this cycle is the single IDLE cycle
    drive('0, '0, 1'b0);
    chk("idle_reset_diff", int'(RESET_DIFF), 1);
    chk("idle_enable", int'(ENABLE_DIFF), 0);

    for (int i = 0; i < 16; i++) begin
      drive(vo[i], vc[i], 1'b0);
      if (i == 0) begin
        chk("run0_enable", int'(ENABLE_DIFF), 1);
        chk("run0_counter", int'(COUNTER), 0);
      end
      if (i == 1) chk_diffs("ramp", -7, -5, -3, -1, 1, 3, 5, 7);
      if (i == 2) chk_diffs("ext", 255, -255, 0, 0, 255, -255, 255, -255);
      if (i == 15) chk("run15_counter", int'(COUNTER), 15);
    end

    // DONE: new inputs must not disturb the last RUN values
    drive(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 1'b0);
    chk("done_enable", int'(ENABLE_DIFF), 0);
    chk("done_reset_diff", int'(RESET_DIFF), 0);
    chk("done_counter", int'(COUNTER), 15);
    chk_diffs("done", 255, -255, 0, 0, 255, -255, 255, -255);
    repeat (5) drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    chk("done_hold_counter", int'(COUNTER), 15);
    chk("done_hold_d1_raw", int'(d1[8:0]), 9'h101);
    chk_diffs("done_hold", 255, -255, 0, 0, 255, -255, 255, -255);

    // Restart, then reset in the middle of RUN at COUNTER = 7
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, (j == 8) ? 1'b1 : 1'b0);
      if (j == 8) chk("mid_counter_before_rst", int'(COUNTER), 7);
    end
    drive('0, '0, 1'b0);
    chk("mid_rst_counter", int'(COUNTER), 0);
    chk("mid_rst_reset_diff", int'(RESET_DIFF), 1);
    chk("mid_rst_enable", int'(ENABLE_DIFF), 0);
    chk_diffs("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);

    // Full RUN after release, then DONE
    for (int i = 0; i < 16; i++) drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    repeat (4) drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    chk("final_counter", int'(COUNTER), 15);
    chk("final_enable", int'(ENABLE_DIFF), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_satd_differences.md
CONTROL_SATD_DIFFERENCES -- requirements
Module: control_satd_differences

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ORG  input  64  eight unsigned 8-bit original samples; sample k = ORG[8k+7:8k].
REQ-005 CUR  input  64  eight unsigned 8-bit current samples; sample k = CUR[8k+7:8k].
REQ-006 ENABLE_DIFF  output  1  high while the block is in RUN; the parent loads 64-bit slice COUNTER of its 1024-bit operands when this is high.
REQ-007 RESET_DIFF  output  1  high while the block is in IDLE; clears the difference registers.
REQ-008 COUNTER  output  4  index of the current 64-bit slice, 0..15.
REQ-009 diff_0 .. diff_7  output  9 each, signed  registered differences ORG sample k minus CUR sample k.

Function
REQ-010 The control FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 All outputs SHALL be decoded from state and registers only (Moore); no combinational path from ORG or CUR to any output.
REQ-012 IDLE: RESET_DIFF=1, ENABLE_DIFF=0, COUNTER=0; next state is RUN unconditionally.
REQ-013 RUN: RESET_DIFF=0, ENABLE_DIFF=1.
REQ-014 In RUN, COUNTER SHALL increment by 1 per clock.
REQ-015 In RUN with COUNTER=15, the next state SHALL be DONE and COUNTER SHALL NOT wrap to 0.
REQ-016 RUN SHALL therefore last exactly 16 consecutive cycles, with COUNTER = 0,1,...,15.
REQ-017 DONE: RESET_DIFF=0, ENABLE_DIFF=0, COUNTER holds 15.
REQ-018 DONE SHALL be terminal; only rst leaves it.
REQ-019 Datapath: on each rising edge with the enable term high, diff_k SHALL load {1'b0,ORG_k} - {1'b0,CUR_k} as a 9-bit two's-complement result.
REQ-020 The enable term SHALL be ENABLE_DIFF.
REQ-021 The result range SHALL be -255..+255 with no overflow or saturation.
REQ-022 Datapath latency SHALL be 1 clock: values present at edge N appear on diff_k after edge N.
REQ-023 When the enable term is low and no clear is active, diff_k SHALL hold its value.
REQ-024 Clear: diff_k SHALL load 0 on any edge where rst=1 or RESET_DIFF=1.
REQ-025 Clear SHALL take priority over load.
REQ-026 All eight lanes SHALL be computed in parallel and independently.
REQ-027 Lane k SHALL use only bits [8k+7:8k] of ORG and CUR.

Reset
REQ-028 rst SHALL take priority over every other condition, in every state including mid-RUN.
REQ-029 On a rising edge with rst=1: state SHALL become IDLE, COUNTER SHALL become 0, and all diff_k SHALL become 0.
REQ-030 In the first cycle after that reset edge, outputs SHALL be ENABLE_DIFF=0, RESET_DIFF=1, COUNTER=0.
REQ-031 After rst is released, the sequence SHALL be 1 IDLE cycle, then 16 RUN cycles, then DONE.
REQ-032 No output SHALL be X after the first reset edge.

Verification
REQ-033 Reset then release -> ENABLE_DIFF low for 1 cycle with RESET_DIFF=1; then ENABLE_DIFF high for exactly 16 cycles with COUNTER 0..15; then ENABLE_DIFF=0, RESET_DIFF=0, COUNTER=15 indefinitely.
REQ-034 In RUN, ORG=0x0807060504030201 and CUR=0x0102030405060708 -> next cycle diff_0..diff_7 = -7,-5,-3,-1,1,3,5,7.
REQ-035 Extremes: ORG byte 0xFF with CUR byte 0x00 -> +255; ORG byte 0x00 with CUR byte 0xFF -> -255 (9'h101); equal bytes -> 0.
REQ-036 In DONE, change ORG and CUR -> all diff_k hold their last RUN values.
REQ-037 Assert rst when COUNTER=7 in RUN -> next cycle COUNTER=0, all diff_k=0, state IDLE; full 16-cycle RUN then follows after release.
REQ-038 Hold rst high for several cycles -> ENABLE_DIFF=0 and COUNTER=0 throughout; the sequence starts only after rst falls.
